baud_ctrl: RTL and testbench

BAUD_CTRL -- requirements
Module: baud_ctrl

---
 rtl/baud_pkg.sv | 22 ++
 rtl/baud_div_cnt.sv | 43 ++++
 rtl/baud_ctrl.sv | 162 ++++++++++++++++
 tb/tb_baud_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared constants and the controller state encoding for the baud timebase.
//   DIV_W       : divisor / counter width
//   DEFAULT_DIV : divisor loaded at reset (50 MHz / 9600 baud -> 5207)
//   MIN_DIV     : smallest divisor the controller will apply
//   baud_state_e: IDLE (stopped), RUN (counting), PEND (counting, new divisor
//                 waiting for the current period to finish)
// -----------------------------------------------------------------------------
package baud_pkg;

    localparam int              DIV_W       = 13;
    localparam logic [DIV_W-1:0] DEFAULT_DIV = 13'h1457;
    localparam logic [DIV_W-1:0] MIN_DIV     = 13'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } baud_state_e;

endpackage

// File: rtl/baud_div_cnt.sv
// -----------------------------------------------------------------------------
// baud_div_cnt
// Period counter for the baud timebase. Counts 0..div and wraps, flagging the
// terminal count (bit boundary) and the half-way count (sample point).
// Ports:
//   clock   : rising-edge clock
//   reset   : asynchronous, active-low
//   run     : count while high; counter is held at 0 while low
//   div     : active divisor; one period is div+1 clocks
//   at_term : count == div this cycle (wrap happens on the next edge)
//   at_mid  : count == div>>1 this cycle
// -----------------------------------------------------------------------------
module baud_div_cnt #(
    parameter int DIV_W = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             at_term,
    output logic             at_mid
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] count;

    assign at_term = (count == div);
    assign at_mid  = (count == (div >> 1));

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!run || at_term) begin
            count <= '0;
        end else begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/baud_ctrl.sv
// -----------------------------------------------------------------------------
// baud_ctrl
// Programmable baud-rate timebase with a valid/ready divisor interface.
// A divisor offered while stopped takes effect immediately; one offered while
// running is parked and applied at the next bit boundary so no period is
// ever cut short or stretched. Divisors below MIN_DIV are clamped and flagged.
//
// Optional feature: define BAUD_CTRL_IRDA_EN to add the irda_win output,
// a 3/16-bit window starting at each baud_tick.
//
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low
//   enable    : run the timebase while high
//   cfg_valid : a new divisor is offered
//   cfg_div   : offered divisor (period = divisor+1 clocks)
//   cfg_ready : divisor can be accepted this cycle (low while one is pending)
//   cfg_err   : one-cycle pulse after an accepted divisor was clamped
//   baud_tick : one-cycle strobe at each bit boundary
//   mid_tick  : one-cycle strobe at mid-bit
//   busy      : timebase is running (RUN or PEND)
//   irda_win  : (BAUD_CTRL_IRDA_EN only) 3/16-bit pulse window
// -----------------------------------------------------------------------------
module baud_ctrl
    import baud_pkg::baud_state_e, baud_pkg::ST_IDLE, baud_pkg::ST_RUN, baud_pkg::ST_PEND;
#(
    parameter int               DIV_W       = baud_pkg::DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = baud_pkg::DEFAULT_DIV,
    parameter logic [DIV_W-1:0] MIN_DIV     = baud_pkg::MIN_DIV
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             baud_tick,
    output logic             mid_tick,
    output logic             busy
`ifdef BAUD_CTRL_IRDA_EN
    ,
    output logic             irda_win
`endif
);

    baud_state_e      state;
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] pending_div;
    logic [DIV_W-1:0] cfg_clamped;
    logic             cfg_fire;
    logic             cfg_low;
    logic             run;
    logic             at_term;
    logic             at_mid;

    assign cfg_ready   = (state != ST_PEND);
    assign busy        = (state != ST_IDLE);
    assign cfg_fire    = cfg_valid && cfg_ready;
    assign cfg_low     = (cfg_div < MIN_DIV);
    assign cfg_clamped = cfg_low ? MIN_DIV : cfg_div;
    // Counting only happens in RUN/PEND with enable still high; a low enable
    // in those states both stops and clears the counter on the same edge.
    assign run         = busy && enable;

    baud_div_cnt #(
        .DIV_W (DIV_W)
    ) u_div_cnt (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .div     (active_div),
        .at_term (at_term),
        .at_mid  (at_mid)
    );

    // Control FSM and divisor registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            active_div  <= DEFAULT_DIV;
            pending_div <= DEFAULT_DIV;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_fire) active_div <= cfg_clamped;
                    if (enable)   state      <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) begin
                        // Stopping anyway, so an accepted divisor applies now.
                        state <= ST_IDLE;
                        if (cfg_fire) active_div <= cfg_clamped;
                    end else if (cfg_fire) begin
                        pending_div <= cfg_clamped;
                        state       <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!enable) begin
                        state      <= ST_IDLE;
                        active_div <= pending_div;
                    end else if (at_term) begin
                        active_div <= pending_div;
                        state      <= ST_RUN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_tick <= 1'b0;
            mid_tick  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            baud_tick <= run && at_term;
            mid_tick  <= run && at_mid;
            cfg_err   <= cfg_fire && cfg_low;
        end
    end

`ifdef BAUD_CTRL_IRDA_EN
    localparam int               WIN_W   = DIV_W - 2;
    localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] next_div;
    logic [DIV_W+1:0] win_prod;
    logic [WIN_W-1:0] win_len;
    logic [WIN_W-1:0] win_cnt;

    // The window belongs to the period that starts at the tick, so in PEND
    // it is sized from the divisor about to become active.
    assign next_div = (state == ST_PEND) ? pending_div : active_div;
    assign win_prod = ({2'b00, next_div} + {{(DIV_W+1){1'b0}}, 1'b1})
                    * {{DIV_W{1'b0}}, 2'b11};
    assign win_len  = WIN_W'(win_prod >> 4);

    // win_cnt holds the number of window cycles still to come after this one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irda_win <= 1'b0;
            win_cnt  <= '0;
        end else if (!run) begin
            irda_win <= 1'b0;
            win_cnt  <= '0;
        end else if (at_term) begin
            irda_win <= (win_len != '0);
            win_cnt  <= (win_len != '0) ? (win_len - WIN_ONE) : '0;
        end else if (win_cnt != '0) begin
            irda_win <= 1'b1;
            win_cnt  <= win_cnt - WIN_ONE;
        end else begin
            irda_win <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_baud_ctrl.sv
// -----------------------------------------------------------------------------
// tb_baud_ctrl
// Two instances share the clock: u_dflt uses the default parameters
// (divisor 5207, MIN_DIV 15); u_fast lowers MIN_DIV to 8 so short divisors
// such as 9 and 19 are applied unclamped. Expected strobe cycles are queued
// as stimulus is driven and popped by a negedge monitor whenever a strobe
// appears. Build with +define+BAUD_CTRL_IRDA_EN to also check irda_win.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_baud_ctrl;

    localparam int DIV_W = 13;

    logic             clock = 1'b0;
    logic             reset;

    logic             d_en, d_cv, d_ready, d_err, d_tick, d_mid, d_busy;
    logic [DIV_W-1:0] d_cd;
    logic             f_en, f_cv, f_ready, f_err, f_tick, f_mid, f_busy;
    logic [DIV_W-1:0] f_cd;
`ifdef BAUD_CTRL_IRDA_EN
    logic             d_irda, f_irda;
`endif

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int q_dtick[$], q_dmid[$], q_derr[$];
    int q_ftick[$], q_fmid[$], q_ferr[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    baud_ctrl u_dflt (
        .clock     (clock),
        .reset     (reset),
        .enable    (d_en),
        .cfg_valid (d_cv),
        .cfg_div   (d_cd),
        .cfg_ready (d_ready),
        .cfg_err   (d_err),
        .baud_tick (d_tick),
        .mid_tick  (d_mid),
        .busy      (d_busy)
`ifdef BAUD_CTRL_IRDA_EN
        ,
        .irda_win  (d_irda)
`endif
    );

    baud_ctrl #(
        .DIV_W   (DIV_W),
        .MIN_DIV (13'd8)
    ) u_fast (
        .clock     (clock),
        .reset     (reset),
        .enable    (f_en),
        .cfg_valid (f_cv),
        .cfg_div   (f_cd),
        .cfg_ready (f_ready),
        .cfg_err   (f_err),
        .baud_tick (f_tick),
        .mid_tick  (f_mid),
        .busy      (f_busy)
`ifdef BAUD_CTRL_IRDA_EN
        ,
        .irda_win  (f_irda)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // Scoreboard monitor: every strobe must match the next expected cycle.
    always @(negedge clock) begin
        if (d_tick) begin
            if (q_dtick.size() == 0) check("d_tick_unexpected", cyc, -1);
            else                     check("d_tick_cycle", cyc, q_dtick.pop_front());
        end
        if (d_mid) begin
            if (q_dmid.size() == 0) check("d_mid_unexpected", cyc, -1);
            else                    check("d_mid_cycle", cyc, q_dmid.pop_front());
        end
        if (d_err) begin
            if (q_derr.size() == 0) check("d_err_unexpected", cyc, -1);
            else                    check("d_err_cycle", cyc, q_derr.pop_front());
        end
        if (f_tick) begin
            if (q_ftick.size() == 0) check("f_tick_unexpected", cyc, -1);
            else                     check("f_tick_cycle", cyc, q_ftick.pop_front());
        end
        if (f_mid) begin
            if (q_fmid.size() == 0) check("f_mid_unexpected", cyc, -1);
            else                    check("f_mid_cycle", cyc, q_fmid.pop_front());
        end
        if (f_err) begin
            if (q_ferr.size() == 0) check("f_err_unexpected", cyc, -1);
            else                    check("f_err_cycle", cyc, q_ferr.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        reset = 1'b0;
        d_en = 1'b0; d_cv = 1'b0; d_cd = '0;
        f_en = 1'b0; f_cv = 1'b0; f_cd = '0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_d_tick", d_tick, 0);
        check("rst_d_mid",  d_mid,  0);
        check("rst_d_err",  d_err,  0);
        check("rst_d_busy", d_busy, 0);
        check("rst_f_busy", f_busy, 0);
`ifdef BAUD_CTRL_IRDA_EN
        check("rst_d_irda", d_irda, 0);
`endif
        reset = 1'b1;
        @(negedge clock);
        check("rel_d_ready", d_ready, 1);
        check("rel_f_ready", f_ready, 1);

        // Default divisor 5207: ticks every 5208 cycles, mid at 2604.
        s = cyc + 1;
        d_en = 1'b1;
        q_dtick.push_back(s + 5208);  q_dtick.push_back(s + 10416);
        q_dmid.push_back(s + 2604);   q_dmid.push_back(s + 7812);
        @(negedge clock);
        check("dflt_busy_on", d_busy, 1);
        wait_cyc(s + 10418);
        d_en = 1'b0;
        wait_cyc(s + 10420);
        check("dflt_busy_off", d_busy, 0);
        check("dflt_tick_q_empty", q_dtick.size(), 0);
        check("dflt_mid_q_empty",  q_dmid.size(),  0);

        // Divisor 9 loaded in IDLE with enable rising the same cycle.
        @(negedge clock);
        s = cyc + 1;
        f_cv = 1'b1; f_cd = 13'd9; f_en = 1'b1;
        q_ftick.push_back(s + 10); q_ftick.push_back(s + 20);
        q_ftick.push_back(s + 30); q_ftick.push_back(s + 50);
        q_fmid.push_back(s + 5);   q_fmid.push_back(s + 15);
        q_fmid.push_back(s + 25);  q_fmid.push_back(s + 40);
        @(negedge clock);
        f_cv = 1'b0;
        check("fast_busy_on", f_busy, 1);

        // Divisor 19 offered at count 3 of the period starting at s+20.
        wait_cyc(s + 23);
        f_cv = 1'b1; f_cd = 13'd19;
        wait_cyc(s + 24);
        f_cv = 1'b0;
        check("pend_ready_lo", f_ready, 0);
        check("pend_busy", f_busy, 1);
        wait_cyc(s + 29);
        check("pend_ready_hold", f_ready, 0);
        wait_cyc(s + 30);
        check("pend_ready_back", f_ready, 1);

        // Divisor 11 goes pending, then enable drops at count 5.
        wait_cyc(s + 52);
        f_cv = 1'b1; f_cd = 13'd11;
        q_fmid.push_back(s + 65);
        q_ftick.push_back(s + 71);
        wait_cyc(s + 53);
        f_cv = 1'b0;
        check("pend2_ready_lo", f_ready, 0);
        wait_cyc(s + 55);
        f_en = 1'b0;
        wait_cyc(s + 56);
        check("drop_busy_off", f_busy, 0);
        check("drop_ready", f_ready, 1);
        wait_cyc(s + 58);
        f_en = 1'b1;
        wait_cyc(s + 59);
        check("restart_busy", f_busy, 1);

        // Reset asserted while baud_tick is high.
        wait_cyc(s + 71);
        #1;
        reset = 1'b0;
        f_en = 1'b0;
        #1;
        check("async_f_tick", f_tick, 0);
        check("async_f_mid",  f_mid,  0);
        check("async_f_err",  f_err,  0);
        check("async_f_busy", f_busy, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rel2_f_ready", f_ready, 1);
        check("rel2_f_busy",  f_busy,  0);
        repeat (3) @(negedge clock);

        // Divisor 4 is clamped to 15: cfg_err pulse, 16-cycle period.
        @(negedge clock);
        s = cyc + 1;
        d_cv = 1'b1; d_cd = 13'd4; d_en = 1'b1;
        q_derr.push_back(s);
        q_dtick.push_back(s + 16); q_dtick.push_back(s + 32);
        q_dmid.push_back(s + 8);   q_dmid.push_back(s + 24);
        @(negedge clock);
        d_cv = 1'b0;
`ifdef BAUD_CTRL_IRDA_EN
        wait_cyc(s + 15);
        check("irda_before", d_irda, 0);
        for (int k = 16; k <= 18; k++) begin
            wait_cyc(s + k);
            check("irda_window", d_irda, 1);
        end
        wait_cyc(s + 19);
        check("irda_after", d_irda, 0);
`endif
        wait_cyc(s + 33);
        d_en = 1'b0;
        wait_cyc(s + 34);
        check("clamp_busy_off", d_busy, 0);
`ifdef BAUD_CTRL_IRDA_EN
        check("irda_idle", d_irda, 0);
`endif
        repeat (4) @(negedge clock);

        check("end_d_tick_q", q_dtick.size(), 0);
        check("end_d_mid_q",  q_dmid.size(),  0);
        check("end_d_err_q",  q_derr.size(),  0);
        check("end_f_tick_q", q_ftick.size(), 0);
        check("end_f_mid_q",  q_fmid.size(),  0);
        check("end_f_err_q",  q_ferr.size(),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
